dist_op_scheduler: RTL and testbench
====================================

# dist_op_scheduler

Sequencer for the multi-cycle distribution unit (DU) in the distribution register path. It accepts one DU operation at a time, counts its latency, and tracks the pending destination distribution register on a single-entry scoreboard. It stalls ID on read-after-write, write-after-write and structural hazards that the EX/MEM distribution forwarding paths cannot cover, and arbitrates the single distribution-register-file (DRF) write port between pipeline writeback and DU completion.

## Interface
Parameters:
- `LAT_W`, default 4: latency field width. Maximum DU latency is 2^LAT_W−1.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `ID_duIssue` input, 1 bit: the instruction in ID is a DU operation.
- `ID_duLatency` input, `LAT_W` bits: DU cycles needed by that operation. A value of 0 is treated as 1.
- `ID_destAddr` input, 5 bits: distribution destination register of the ID instruction.
- `ID_DRegWrite` input, 1 bit: the ID instruction writes a distribution register through the normal pipeline.
- `ID_sourceAddr1` / `ID_sourceAddr2` input, 5 bits each: distribution source registers.
- `ID_useSrc1` / `ID_useSrc2` input, 1 bit each: the corresponding source is actually read.
- `ID_flush` input, 1 bit: squash the ID instruction. A flushed issue is never accepted.
- `WB_DRegWrite` input, 1 bit: pipeline writeback requests the DRF write port.
- `WB_destAddr` input, 5 bits: pipeline writeback destination.
- `ID_stall` output, 1 bit: hold IF/ID.
- `DU_start` output, 1 bit: one-cycle pulse; the DU latches its operands in this cycle.
- `DU_busy` output, 1 bit: the DU is occupied (BUSY or DRAIN).
- `DRF_wrEn` output, 1 bit: DRF write enable.
- `DRF_wrAddr` output, 5 bits: DRF write address.
- `DRF_wrSel` output, 1 bit: DRF write data select; 0 = pipeline WB data, 1 = DU result.

## Operation
- State machine has three states:
  - IDLE: DU free.
  - BUSY: counting latency.
  - DRAIN: DU result is ready and waiting for the write port.
- Scoreboard registers:
  - `pendValid`, `pendAddr`: the pending DU destination.
  - `cnt`: `LAT_W`-bit latency counter.
- Accept condition: `accept = ID_duIssue & ~ID_flush & state==IDLE`.
  - On accept, `DU_start`=1.
  - `pendValid` is loaded with (`ID_destAddr`≠0); `pendAddr` is loaded with `ID_destAddr`.
  - Let L = max(`ID_duLatency`, 1). If L==1 the next state is DRAIN. Otherwise the next state is BUSY with `cnt`=L−1.
- In BUSY: if `cnt`==1 the next state is DRAIN; otherwise `cnt` decrements.
- In DRAIN, the write port is arbitrated as follows:
  - If `WB_DRegWrite`=1, WB has priority: `DRF_wrEn`=1, `DRF_wrAddr`=`WB_destAddr`, `DRF_wrSel`=0. The state stays DRAIN.
  - If `WB_DRegWrite`=0: `DRF_wrEn`=`pendValid`, `DRF_wrAddr`=`pendAddr`, `DRF_wrSel`=1. The next state is IDLE and `pendValid` clears.
- Outside DRAIN the write port passes WB through: `DRF_wrEn`=`WB_DRegWrite`, `DRF_wrAddr`=`WB_destAddr`, `DRF_wrSel`=0.
- A destination of 0 still occupies the DU for the full latency, but it never sets `pendValid` and never writes the DRF.
- `ID_stall` is the OR of the following terms, all suppressed by `ID_flush`:
  - RAW: `pendValid` & ((`ID_useSrc1` & `ID_sourceAddr1`==`pendAddr`) | (`ID_useSrc2` & `ID_sourceAddr2`==`pendAddr`)).
  - WAW: `pendValid` & `ID_DRegWrite` & `ID_destAddr`==`pendAddr`.
  - Structural: `ID_duIssue` & state≠IDLE.
  - Drain: state==DRAIN. This freezes new writers, so the WB pipeline empties within 3 cycles and the DU write is guaranteed to happen.
- `DU_busy` = (state≠IDLE).

## Timing
- Reset is synchronous and takes priority over all other events, including mid-BUSY and mid-DRAIN.
  - Next state after reset: IDLE, `pendValid`=0, `cnt`=0.
  - During a cycle with `reset`=1, all outputs are forced to 0.
  - An in-flight DU result is discarded.
- `ID_stall`, `DU_start` and the `DRF_*` outputs are combinational from the current state and current inputs. All state is registered.
- For an operation accepted in cycle T with latency L:
  - DRAIN is entered at cycle T+L.
  - The earliest DU write is in cycle T+L.
  - The write is delayed by one cycle for each cycle of `WB_DRegWrite`=1.
- Back-to-back DU operations: the second operation is accepted no earlier than the cycle after the DU write. That cycle is IDLE, and `ID_stall` is 0 there for a non-dependent instruction.
- Dependent instructions are released in the cycle after the DU write. The DRF is write-before-read, so no extra forwarding path is needed.
- An issue arriving in the same cycle that DRAIN completes is stalled by the structural term and accepted in the next cycle.

## Structure
- Shared package holds:
  - The state encoding (IDLE=0, BUSY=1, DRAIN=2).
  - `DRF_SEL_WB`=0 and `DRF_SEL_DU`=1.
  - The register address width of 5.
- One sub-module, `dist_hazard_compare`, holds the combinational RAW/WAW comparators. It is instantiated once.
- FSM, counter, scoreboard and write-port mux stay in the top level.

## Test plan
- Issue with dest=5, L=3 at T=10, WB idle:
  - `DU_start` is high in cycle 10.
  - `DU_busy` is high in cycles 11–13.
  - In cycle 13: `DRF_wrEn`=1, addr=5, sel=1.
  - IDLE in cycle 14.
- Same issue, plus an ID instruction reading source 5 at cycle 11:
  - `ID_stall`=1 in cycles 11–13.
  - `ID_stall`=0 in cycle 14.
- DRAIN entered at cycle 13 with `WB_DRegWrite`=1 (addr 7) in cycles 13–14:
  - WB writes addr 7 with sel=0 in cycles 13 and 14.
  - DU writes addr 5 in cycle 15.
- L=0 and L=1, each with dest=9: DRAIN in T+1, write in T+1.
- Dest=0, L=2:
  - No `DRF_wrEn` from the DU.
  - A read of source 0 is never stalled.
  - A second issue is accepted at T+3.
- `reset` asserted in BUSY with `cnt`=4:
  - Outputs are 0 during the reset cycle.
  - IDLE next cycle, no DU write.
  - A new issue is accepted immediately.

Source files
------------

// File: rtl/dist_op_scheduler_pkg.sv
// Shared definitions for the distribution-unit scheduler: state encoding,
// DRF write-select codes and register address width.
package dist_op_scheduler_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } duState_t;

  localparam logic DRF_SEL_WB = 1'b0;
  localparam logic DRF_SEL_DU = 1'b1;

endpackage

// File: rtl/dist_hazard_compare.sv
// Combinational RAW/WAW comparators between the ID instruction and the
// single pending DU destination on the scoreboard.
module dist_hazard_compare
  import dist_op_scheduler_pkg::*;
(
  input  logic                  pendValid,
  input  logic [REG_ADDR_W-1:0] pendAddr,
  input  logic [REG_ADDR_W-1:0] sourceAddr1,
  input  logic [REG_ADDR_W-1:0] sourceAddr2,
  input  logic                  useSrc1,
  input  logic                  useSrc2,
  input  logic [REG_ADDR_W-1:0] destAddr,
  input  logic                  dRegWrite,
  output logic                  rawHazard,
  output logic                  wawHazard
);

  logic src1Hit;
  logic src2Hit;

  // Register 0 never sets pendValid, so reads of r0 can never match here.
  assign src1Hit   = useSrc1 & (sourceAddr1 == pendAddr);
  assign src2Hit   = useSrc2 & (sourceAddr2 == pendAddr);
  assign rawHazard = pendValid & (src1Hit | src2Hit);
  assign wawHazard = pendValid & dRegWrite & (destAddr == pendAddr);

endmodule

// File: rtl/dist_op_scheduler.sv
// Sequencer for the multi-cycle distribution unit: latency counting,
// single-entry destination scoreboard, ID hazard stall and DRF write-port arbitration.
module dist_op_scheduler
  import dist_op_scheduler_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_duIssue,
  input  logic [LAT_W-1:0]      ID_duLatency,
  input  logic [REG_ADDR_W-1:0] ID_destAddr,
  input  logic                  ID_DRegWrite,
  input  logic [REG_ADDR_W-1:0] ID_sourceAddr1,
  input  logic [REG_ADDR_W-1:0] ID_sourceAddr2,
  input  logic                  ID_useSrc1,
  input  logic                  ID_useSrc2,
  input  logic                  ID_flush,
  input  logic                  WB_DRegWrite,
  input  logic [REG_ADDR_W-1:0] WB_destAddr,
  output logic                  ID_stall,
  output logic                  DU_start,
  output logic                  DU_busy,
  output logic                  DRF_wrEn,
  output logic [REG_ADDR_W-1:0] DRF_wrAddr,
  output logic                  DRF_wrSel
);

  duState_t              state, stateNext;
  logic [LAT_W-1:0]      cnt, cntNext;
  logic                  pendValid, pendValidNext;
  logic [REG_ADDR_W-1:0] pendAddr, pendAddrNext;
  logic [LAT_W-1:0]      effLat;
  logic                  accept;
  logic                  rawHazard;
  logic                  wawHazard;

  dist_hazard_compare u_hazard (
    .pendValid   (pendValid),
    .pendAddr    (pendAddr),
    .sourceAddr1 (ID_sourceAddr1),
    .sourceAddr2 (ID_sourceAddr2),
    .useSrc1     (ID_useSrc1),
    .useSrc2     (ID_useSrc2),
    .destAddr    (ID_destAddr),
    .dRegWrite   (ID_DRegWrite),
    .rawHazard   (rawHazard),
    .wawHazard   (wawHazard)
  );

  // A requested latency of zero behaves exactly like a single-cycle op.
  assign effLat = (ID_duLatency == '0) ? LAT_W'(1) : ID_duLatency;
  assign accept = ID_duIssue & ~ID_flush & (state == IDLE);

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    pendValidNext = pendValid;
    pendAddrNext  = pendAddr;
    case (state)
      IDLE: begin
        if (accept) begin
          pendValidNext = |ID_destAddr;
          pendAddrNext  = ID_destAddr;
          if (effLat == LAT_W'(1)) begin
            stateNext = DRAIN;
          end else begin
            stateNext = BUSY;
            cntNext   = effLat - LAT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == LAT_W'(1)) begin
          stateNext = DRAIN;
        end else begin
          cntNext = cnt - LAT_W'(1);
        end
      end
      DRAIN: begin
        // WB owns the port while it writes; the DU result waits its turn.
        if (!WB_DRegWrite) begin
          stateNext     = IDLE;
          pendValidNext = 1'b0;
        end
      end
      default: begin
        stateNext     = IDLE;
        pendValidNext = 1'b0;
      end
    endcase
  end

  always_comb begin
    ID_stall   = 1'b0;
    DU_start   = 1'b0;
    DU_busy    = 1'b0;
    DRF_wrEn   = 1'b0;
    DRF_wrAddr = '0;
    DRF_wrSel  = DRF_SEL_WB;
    if (!reset) begin
      DU_start = accept;
      DU_busy  = (state != IDLE);
      ID_stall = ~ID_flush & (rawHazard | wawHazard |
                              (ID_duIssue & (state != IDLE)) |
                              (state == DRAIN));
      if ((state == DRAIN) && !WB_DRegWrite) begin
        DRF_wrEn   = pendValid;
        DRF_wrAddr = pendAddr;
        DRF_wrSel  = DRF_SEL_DU;
      end else begin
        DRF_wrEn   = WB_DRegWrite;
        DRF_wrAddr = WB_destAddr;
        DRF_wrSel  = DRF_SEL_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pendValid <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      pendValid <= pendValidNext;
    end
  end

  // Address is only meaningful while pendValid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pendAddr <= pendAddrNext;
  end

endmodule

// File: tb/tb_dist_op_scheduler.sv
// Randomized and directed bench for dist_op_scheduler against a
// cycle-accurate behavioural model built on absolute completion times.
module tb_dist_op_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_duIssue;
  logic [3:0] ID_duLatency;
  logic [4:0] ID_destAddr;
  logic       ID_DRegWrite;
  logic [4:0] ID_sourceAddr1;
  logic [4:0] ID_sourceAddr2;
  logic       ID_useSrc1;
  logic       ID_useSrc2;
  logic       ID_flush;
  logic       WB_DRegWrite;
  logic [4:0] WB_destAddr;
  logic       ID_stall;
  logic       DU_start;
  logic       DU_busy;
  logic       DRF_wrEn;
  logic [4:0] DRF_wrAddr;
  logic       DRF_wrSel;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  // Model: the DU is occupied from acceptance until its result is written;
  // the result is ready from the absolute cycle mDoneAt onwards.
  bit         mOcc    = 1'b0;
  int         mDoneAt = 0;
  bit         mPv     = 1'b0;
  logic [4:0] mPa     = '0;

  always #5 clk = ~clk;

  dist_op_scheduler #(.LAT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_duIssue     (ID_duIssue),
    .ID_duLatency   (ID_duLatency),
    .ID_destAddr    (ID_destAddr),
    .ID_DRegWrite   (ID_DRegWrite),
    .ID_sourceAddr1 (ID_sourceAddr1),
    .ID_sourceAddr2 (ID_sourceAddr2),
    .ID_useSrc1     (ID_useSrc1),
    .ID_useSrc2     (ID_useSrc2),
    .ID_flush       (ID_flush),
    .WB_DRegWrite   (WB_DRegWrite),
    .WB_destAddr    (WB_destAddr),
    .ID_stall       (ID_stall),
    .DU_start       (DU_start),
    .DU_busy        (DU_busy),
    .DRF_wrEn       (DRF_wrEn),
    .DRF_wrAddr     (DRF_wrAddr),
    .DRF_wrSel      (DRF_wrSel)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge and park inputs at idle.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    reset          = 1'b0;
    ID_duIssue     = 1'b0;
    ID_duLatency   = '0;
    ID_destAddr    = '0;
    ID_DRegWrite   = 1'b0;
    ID_sourceAddr1 = '0;
    ID_sourceAddr2 = '0;
    ID_useSrc1     = 1'b0;
    ID_useSrc2     = 1'b0;
    ID_flush       = 1'b0;
    WB_DRegWrite   = 1'b0;
    WB_destAddr    = '0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model.
  task automatic tick();
    bit         drn, eStall, eStart, eBusy, eEn, eSel, raw, waw;
    logic [4:0] eAddr;
    int         lat;
    @(negedge clk);
    drn    = mOcc && (cyc >= mDoneAt);
    eStall = 0; eStart = 0; eBusy = 0; eEn = 0; eSel = 0; eAddr = '0;
    if (!reset) begin
      raw    = mPv && ((ID_useSrc1 && ID_sourceAddr1 == mPa) ||
                       (ID_useSrc2 && ID_sourceAddr2 == mPa));
      waw    = mPv && ID_DRegWrite && (ID_destAddr == mPa);
      eStall = !ID_flush && (raw || waw || (ID_duIssue && mOcc) || drn);
      eStart = ID_duIssue && !ID_flush && !mOcc;
      eBusy  = mOcc;
      if (drn && !WB_DRegWrite) begin
        eEn = mPv; eAddr = mPa; eSel = 1'b1;
      end else begin
        eEn = WB_DRegWrite; eAddr = WB_destAddr; eSel = 1'b0;
      end
    end
    checkVal("ID_stall", ID_stall, eStall);
    checkVal("DU_start", DU_start, eStart);
    checkVal("DU_busy", DU_busy, eBusy);
    checkVal("DRF_wrEn", DRF_wrEn, eEn);
    checkVal("DRF_wrAddr", DRF_wrAddr, eAddr);
    checkVal("DRF_wrSel", DRF_wrSel, eSel);
    if (reset) begin
      mOcc = 0;
      mPv  = 0;
    end else begin
      if (drn && !WB_DRegWrite) begin
        mOcc = 0;
        mPv  = 0;
      end
      if (eStart) begin
        lat     = (ID_duLatency == 0) ? 1 : int'(ID_duLatency);
        mOcc    = 1;
        mDoneAt = cyc + lat;
        mPv     = (ID_destAddr != 0);
        mPa     = ID_destAddr;
      end
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      nextCycle(); reset = 1'b1; tick();
      checkVal("rstStall", ID_stall, 0);
      checkVal("rstBusy", DU_busy, 0);
    end
    idleCycles(3);

    // dest 5, latency 3, with a dependent read in the following cycles
    nextCycle(); ID_duIssue = 1; ID_duLatency = 3; ID_destAddr = 5; tick();
    checkVal("s1Start", DU_start, 1);
    for (int i = 1; i <= 3; i++) begin
      nextCycle(); ID_useSrc1 = 1; ID_sourceAddr1 = 5; tick();
      checkVal("s1RawStall", ID_stall, 1);
      checkVal("s1Busy", DU_busy, 1);
      if (i == 3) begin
        checkVal("s1WrEn", DRF_wrEn, 1);
        checkVal("s1WrAddr", DRF_wrAddr, 5);
        checkVal("s1WrSel", DRF_wrSel, 1);
      end
    end
    nextCycle(); ID_useSrc1 = 1; ID_sourceAddr1 = 5; tick();
    checkVal("s1Release", ID_stall, 0);
    checkVal("s1Idle", DU_busy, 0);

    // WB holds the port for two DRAIN cycles
    nextCycle(); ID_duIssue = 1; ID_duLatency = 3; ID_destAddr = 5; tick();
    idleCycles(2);
    for (int i = 0; i < 2; i++) begin
      nextCycle(); WB_DRegWrite = 1; WB_destAddr = 7; tick();
      checkVal("s2WbAddr", DRF_wrAddr, 7);
      checkVal("s2WbSel", DRF_wrSel, 0);
    end
    nextCycle(); tick();
    checkVal("s2DuAddr", DRF_wrAddr, 5);
    checkVal("s2DuSel", DRF_wrSel, 1);
    idleCycles(1);

    // latency 0 and 1 both complete in the next cycle
    for (int l = 0; l < 2; l++) begin
      nextCycle(); ID_duIssue = 1; ID_duLatency = 4'(l); ID_destAddr = 9; tick();
      nextCycle(); tick();
      checkVal("s3WrEn", DRF_wrEn, 1);
      checkVal("s3WrAddr", DRF_wrAddr, 9);
      idleCycles(1);
    end

    // destination 0: full latency, no write, r0 reads never stall
    nextCycle(); ID_duIssue = 1; ID_duLatency = 2; ID_destAddr = 0; tick();
    nextCycle(); ID_useSrc1 = 1; ID_sourceAddr1 = 0; tick();
    checkVal("s4R0Stall", ID_stall, 0);
    nextCycle(); tick();
    checkVal("s4NoWrite", DRF_wrEn, 0);
    nextCycle(); ID_duIssue = 1; ID_duLatency = 2; ID_destAddr = 4; tick();
    checkVal("s4Reissue", DU_start, 1);
    idleCycles(3);

    // reset while BUSY with cnt=4 discards the result
    nextCycle(); ID_duIssue = 1; ID_duLatency = 6; ID_destAddr = 3; tick();
    idleCycles(1);
    nextCycle(); reset = 1; WB_DRegWrite = 1; WB_destAddr = 3; tick();
    checkVal("s5RstWrEn", DRF_wrEn, 0);
    checkVal("s5RstBusy", DU_busy, 0);
    nextCycle(); ID_duIssue = 1; ID_duLatency = 1; ID_destAddr = 2; tick();
    checkVal("s5Accept", DU_start, 1);
    idleCycles(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      reset          = ($urandom_range(0, 99) < 2);
      ID_duIssue     = ($urandom_range(0, 99) < 35);
      ID_duLatency   = 4'($urandom_range(0, 15));
      ID_destAddr    = 5'($urandom_range(0, 7));
      ID_DRegWrite   = 1'($urandom_range(0, 1));
      ID_sourceAddr1 = 5'($urandom_range(0, 7));
      ID_sourceAddr2 = 5'($urandom_range(0, 7));
      ID_useSrc1     = 1'($urandom_range(0, 1));
      ID_useSrc2     = 1'($urandom_range(0, 1));
      ID_flush       = ($urandom_range(0, 99) < 10);
      WB_DRegWrite   = ($urandom_range(0, 99) < 40);
      WB_destAddr    = 5'($urandom_range(0, 31));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
